reg_dump_sequencer: RTL and testbench

- Sits downstream of the CPU top's register observation port (regNo out to the CPU, val back in).
- On a dump request, walks a range of register numbers and captures each 32-bit value.
- Emits the captured values as a byte stream over a valid/ready handshake, for a UART or testbench sink.
- Purely an observer: never writes CPU state.

---
 rtl/reg_dump_sequencer_pkg.sv | 37 +++
 rtl/reg_dump_sequencer_serializer.sv | 58 +++++
 rtl/reg_dump_sequencer.sv | 87 ++++++++
 tb/tb_reg_dump_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_dump_sequencer_pkg.sv
// Shared types and constants for the register dump sequencer: FSM state
// encoding, bus widths and the per-register byte layout helpers.
package reg_dump_sequencer_pkg;

    localparam int REG_IDX_W     = 5;
    localparam int DATA_W        = 32;
    localparam int BYTE_W        = 8;
    localparam int BYTE_CNT_W    = 3;
    localparam int LAST_BYTE_IDX = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        LATCH = 3'd2,
        SEND  = 3'd3,
        DONE  = 3'd4
    } seq_state_t;

    // Byte 0 is the optional index header; bytes 1..4 carry the word MSB first.
    function automatic int bytes_per_reg(input int header_en);
        return (header_en != 0) ? 5 : 4;
    endfunction

    function automatic logic [BYTE_W-1:0] word_byte(input logic [DATA_W-1:0]     word,
                                                     input logic [BYTE_CNT_W-1:0] idx);
        logic [BYTE_W-1:0] b;
        case (idx)
            3'd1:    b = word[31:24];
            3'd2:    b = word[23:16];
            3'd3:    b = word[15:8];
            3'd4:    b = word[7:0];
            default: b = '0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/reg_dump_sequencer_serializer.sv
// Serialises one captured 32-bit register word (plus optional index header)
// into bytes over a valid/ready handshake.
module word_byte_serializer
    import reg_dump_sequencer_pkg::*;
#(
    parameter int HEADER_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [DATA_W-1:0]    word,
    input  logic [REG_IDX_W-1:0] idx,
    output logic [BYTE_W-1:0]    out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 last_accepted
);

    localparam int BYTES_PER_REG = bytes_per_reg(HEADER_EN);
    localparam logic [BYTE_CNT_W-1:0] FIRST_BYTE =
        BYTE_CNT_W'(LAST_BYTE_IDX + 1 - BYTES_PER_REG);
    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(LAST_BYTE_IDX);

    // Handshake: a byte transfers on a rising clk where out_valid & out_ready;
    // out_data/out_valid never change while out_valid=1 and out_ready=0.
    logic [DATA_W-1:0]     word_q;
    logic [BYTE_CNT_W-1:0] byte_cnt;
    logic [BYTE_CNT_W-1:0] next_cnt;
    logic                  accept;
    logic [BYTE_W-1:0]     header_byte;

    assign accept        = out_valid & out_ready;
    assign last_accepted = accept && (byte_cnt == LAST_BYTE);
    assign next_cnt      = byte_cnt + 3'd1;
    assign header_byte   = {{(BYTE_W-REG_IDX_W){1'b0}}, idx};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q    <= '0;
            byte_cnt  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            word_q    <= word;
            byte_cnt  <= FIRST_BYTE;
            out_valid <= 1'b1;
            out_data  <= (FIRST_BYTE == '0) ? header_byte : word_byte(word, FIRST_BYTE);
        end else if (accept) begin
            if (byte_cnt == LAST_BYTE) begin
                out_valid <= 1'b0;
            end else begin
                byte_cnt <= next_cnt;
                out_data <= word_byte(word_q, next_cnt);
            end
        end
    end

endmodule

// File: rtl/reg_dump_sequencer.sv
// Walks register numbers FIRST_REG..LAST_REG on the CPU observation port and
// streams each captured value as bytes; never writes CPU state.
module reg_dump_sequencer
    import reg_dump_sequencer_pkg::*;
#(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31,
    parameter int HEADER_EN = 1
) (
    input  logic                 clk,
    input  logic                 startin,
    input  logic                 dump_req,
    output logic [REG_IDX_W-1:0] regNo,
    input  logic [DATA_W-1:0]    val,
    output logic [BYTE_W-1:0]    out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done,
    output seq_state_t           state_dbg
);

    localparam logic [REG_IDX_W-1:0] FIRST_IDX = REG_IDX_W'(FIRST_REG);
    localparam logic [REG_IDX_W-1:0] LAST_IDX  = REG_IDX_W'(LAST_REG);

    seq_state_t state;
    logic       load;
    logic       last_accepted;

    assign state_dbg = state;
    // val is only ever captured here, one cycle after regNo settled in ADDR.
    assign load      = (state == LATCH);

    word_byte_serializer #(
        .HEADER_EN(HEADER_EN)
    ) u_ser (
        .clk          (clk),
        .rst_n        (startin),
        .load         (load),
        .word         (val),
        .idx          (regNo),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .last_accepted(last_accepted)
    );

    always_ff @(posedge clk or negedge startin) begin
        if (!startin) begin
            state <= IDLE;
            regNo <= FIRST_IDX;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dump_req) begin
                        state <= ADDR;
                        regNo <= FIRST_IDX;
                        busy  <= 1'b1;
                    end
                end
                ADDR:  state <= LATCH;
                LATCH: state <= SEND;
                SEND: begin
                    if (last_accepted) begin
                        if (regNo == LAST_IDX) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            regNo <= regNo + 5'd1;
                            state <= ADDR;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    regNo <= FIRST_IDX;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_sequencer.sv
// Scoreboard bench: two sequencer instances (full default dump, and a single
// register without header) checked against a register-array reference model.
module tb_reg_dump_sequencer;
    import reg_dump_sequencer_pkg::*;

    localparam int D0_FIRST = 0;
    localparam int D0_LAST  = 31;
    localparam int D0_HDR   = 1;
    localparam int D1_FIRST = 31;
    localparam int D1_LAST  = 31;
    localparam int D1_HDR   = 0;

    logic        clk;
    logic        startin;
    logic        dump_req[2];
    logic        out_ready[2];
    logic [4:0]  reg_no[2];
    logic [31:0] val[2];
    logic [7:0]  out_data[2];
    logic        out_valid[2];
    logic        busy[2];
    logic        done[2];
    seq_state_t  st_dbg[2];

    logic [31:0] rf0[32];
    logic [31:0] rf1[32];
    logic [7:0]  exp_q0[$];
    logic [7:0]  exp_q1[$];

    bit          rand_ready[2];
    bit          lat_check[2];
    bit          stalled[2];
    logic [7:0]  held[2];
    int          accept_cyc[2];
    int          acc_cnt[2];
    int          done_cnt[2];
    int          cyc;
    int          checks;
    int          errors;

    assign val[0] = rf0[reg_no[0]];
    assign val[1] = rf1[reg_no[1]];

    reg_dump_sequencer #(.FIRST_REG(D0_FIRST), .LAST_REG(D0_LAST), .HEADER_EN(D0_HDR)) u_dut0 (
        .clk(clk), .startin(startin), .dump_req(dump_req[0]), .regNo(reg_no[0]), .val(val[0]),
        .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .busy(busy[0]), .done(done[0]), .state_dbg(st_dbg[0]));

    reg_dump_sequencer #(.FIRST_REG(D1_FIRST), .LAST_REG(D1_LAST), .HEADER_EN(D1_HDR)) u_dut1 (
        .clk(clk), .startin(startin), .dump_req(dump_req[1]), .regNo(reg_no[1]), .val(val[1]),
        .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .busy(busy[1]), .done(done[1]), .state_dbg(st_dbg[1]));

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- helpers ----------------
    function automatic int first_of(input int d);
        return (d == 0) ? D0_FIRST : D1_FIRST;
    endfunction

    function automatic int last_of(input int d);
        return (d == 0) ? D0_LAST : D1_LAST;
    endfunction

    function automatic int hdr_of(input int d);
        return (d == 0) ? D0_HDR : D1_HDR;
    endfunction

    // Reference timing: dump_req accept edge, then per register one address,
    // one capture and one cycle per streamed byte.
    function automatic int lat_of(input int d);
        return (last_of(d) - first_of(d) + 1) * (2 + ((hdr_of(d) != 0) ? 5 : 4));
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic logic [7:0] pop_exp(input int d);
        return (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
    endfunction

    task automatic push_exp(input int d, input logic [7:0] v);
        if (d == 0) exp_q0.push_back(v);
        else        exp_q1.push_back(v);
    endtask

    task automatic chk(input logic ok, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_expected(input int d);
        logic [31:0] w;
        for (int r = first_of(d); r <= last_of(d); r++) begin
            w = (d == 0) ? rf0[r] : rf1[r];
            if (hdr_of(d) != 0) push_exp(d, 8'(r));
            for (int b = 3; b >= 0; b--) push_exp(d, w[8*b +: 8]);
        end
    endtask

    task automatic issue(input int d, input bit lat);
        @(posedge clk); #1;
        dump_req[d] = 1'b1;
        push_expected(d);
        lat_check[d] = lat;
        @(posedge clk); #1;
        accept_cyc[d] = cyc;
        dump_req[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input int budget);
        int start_cnt;
        int n;
        start_cnt = done_cnt[d];
        n = 0;
        while (done_cnt[d] == start_cnt && n < budget) begin
            @(negedge clk); #2;
            n++;
        end
        chk(done_cnt[d] == start_cnt + 1, "done_seen", done_cnt[d] - start_cnt, 1);
        repeat (3) @(negedge clk);
        #2;
        chk(done_cnt[d] == start_cnt + 1, "done_once", done_cnt[d] - start_cnt, 1);
        chk(busy[d] == 1'b0, "idle_after_done", busy[d], 0);
        chk(reg_no[d] == 5'(first_of(d)), "regno_rewind", reg_no[d], first_of(d));
        lat_check[d] = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++)
                out_ready[d] = rand_ready[d] ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!startin) begin
                stalled[d] = 1'b0;
            end else begin
                if (stalled[d])
                    chk(out_valid[d] && out_data[d] == held[d], "stall_hold",
                        {out_valid[d], out_data[d]}, {1'b1, held[d]});
                if (out_valid[d])
                    chk(busy[d] == 1'b1, "busy_while_valid", busy[d], 1);
                chk(int'(reg_no[d]) >= first_of(d) && int'(reg_no[d]) <= last_of(d),
                    "regno_range", reg_no[d], last_of(d));
                if (out_valid[d] && out_ready[d]) begin
                    logic [7:0] e;
                    acc_cnt[d]++;
                    if (qsize(d) == 0) begin
                        chk(1'b0, "unexpected_byte", out_data[d], 0);
                    end else begin
                        e = pop_exp(d);
                        chk(out_data[d] == e, "stream_byte", out_data[d], e);
                    end
                end
                stalled[d] = out_valid[d] && !out_ready[d];
                held[d]    = out_data[d];
                if (done[d]) begin
                    done_cnt[d]++;
                    chk(qsize(d) == 0, "bytes_left_at_done", qsize(d), 0);
                    chk(busy[d] == 1'b0, "busy_at_done", busy[d], 0);
                    if (lat_check[d])
                        chk(cyc - accept_cyc[d] == lat_of(d), "done_latency",
                            cyc - accept_cyc[d], lat_of(d));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int base;
        int n;
        int saved;
        checks = 0;
        errors = 0;
        startin = 1'b0;
        dump_req[0] = 1'b0;
        dump_req[1] = 1'b0;
        rand_ready[0] = 1'b1;
        rand_ready[1] = 1'b1;
        lat_check[0] = 1'b0;
        lat_check[1] = 1'b0;
        for (int d = 0; d < 2; d++) begin
            acc_cnt[d] = 0;
            done_cnt[d] = 0;
            accept_cyc[d] = 0;
            stalled[d] = 1'b0;
            held[d] = '0;
        end
        for (int i = 0; i < 32; i++) begin
            rf0[i] = 32'hA500_0000 | 32'(i);
            rf1[i] = 32'hDEAD_BEEF;
        end

        // Reset held with random inputs.
        repeat (6) begin
            @(posedge clk); #1;
            dump_req[0] = 1'($urandom_range(0, 1));
            dump_req[1] = 1'($urandom_range(0, 1));
            @(negedge clk); #2;
            for (int d = 0; d < 2; d++) begin
                chk(reg_no[d] == 5'(first_of(d)), "rst_regno", reg_no[d], first_of(d));
                chk(out_valid[d] == 1'b0, "rst_valid", out_valid[d], 0);
                chk(out_data[d] == 8'h00, "rst_data", out_data[d], 0);
                chk(busy[d] == 1'b0, "rst_busy", busy[d], 0);
                chk(done[d] == 1'b0, "rst_done", done[d], 0);
                chk(st_dbg[d] == IDLE, "rst_state", st_dbg[d], IDLE);
            end
        end
        dump_req[0] = 1'b0;
        dump_req[1] = 1'b0;
        @(negedge clk); #2;
        startin = 1'b1;
        rand_ready[0] = 1'b0;
        rand_ready[1] = 1'b0;

        // Full dumps with the sink always ready.
        issue(0, 1'b1);
        wait_done(0, 400);
        issue(1, 1'b1);
        wait_done(1, 50);

        // Same register contents under random backpressure.
        rand_ready[0] = 1'b1;
        rand_ready[1] = 1'b1;
        issue(0, 1'b0);
        wait_done(0, 3000);
        issue(1, 1'b0);
        wait_done(1, 200);

        // Random register contents.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 32; i++) begin
                rf0[i] = $urandom;
                rf1[i] = $urandom;
            end
            issue(0, 1'b0);
            issue(1, 1'b0);
            wait_done(1, 200);
            wait_done(0, 3000);
        end

        // Second request while busy must be ignored.
        rand_ready[0] = 1'b0;
        base = acc_cnt[0];
        issue(0, 1'b1);
        repeat (9) @(posedge clk);
        #1 dump_req[0] = 1'b1;
        @(posedge clk); #1;
        dump_req[0] = 1'b0;
        wait_done(0, 400);
        chk(acc_cnt[0] - base == 160, "byte_total", acc_cnt[0] - base, 160);
        saved = done_cnt[0];
        repeat (300) @(negedge clk);
        #2;
        chk(done_cnt[0] == saved, "no_queued_dump", done_cnt[0] - saved, 0);
        chk(busy[0] == 1'b0, "idle_after_ignored_req", busy[0], 0);

        // Reset while reg 5 byte 2 is on the bus.
        rand_ready[0] = 1'b1;
        for (int i = 0; i < 32; i++) rf0[i] = $urandom;
        base = acc_cnt[0];
        issue(0, 1'b0);
        n = 0;
        while (!(acc_cnt[0] - base == 27 && out_valid[0]) && n < 3000) begin
            @(negedge clk); #2;
            n++;
        end
        chk(n < 3000, "reach_reg5_byte2", n, 3000);
        chk(reg_no[0] == 5'd5, "abort_point_regno", reg_no[0], 5);
        saved = done_cnt[0];
        startin = 1'b0;
        #1;
        chk(out_valid[0] == 1'b0, "abort_valid_drop", out_valid[0], 0);
        chk(busy[0] == 1'b0, "abort_busy_drop", busy[0], 0);
        exp_q0.delete();
        repeat (3) @(negedge clk);
        #2;
        startin = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk(done_cnt[0] == saved, "no_done_after_abort", done_cnt[0] - saved, 0);
        rand_ready[0] = 1'b0;
        issue(0, 1'b1);
        wait_done(0, 400);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
